aoi_cell_bist_ctrl: RTL and testbench
=====================================

Name: aoi_cell_bist_ctrl

Overview:
Self-test sequencer for the AOI cell, X = ~((A1&A2)|(A3&A4)|B1). On `start` it drives all 32 input combinations into one cell instance. For each vector it waits a programmable settle time, samples X and compares it against an internal golden model. It counts mismatches and records the first failing vector, then reports pass/fail with a done pulse. It sits beside the cell in the test wrapper and owns the cell's inputs while `busy`.

Parameters:
SETTLE_CYC, 2, cycles each vector is held before X is sampled; legal range 1..255
CNT_W, 8, width of the internal settle counter; must satisfy 2^CNT_W > SETTLE_CYC

Ports:
clk  input  1  single clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to run the sweep; ignored unless in IDLE
abort  input  1  terminates a run, returns to IDLE; no done pulse
dut_a1  output  1  drive to cell A1 (= vec[0])
dut_a2  output  1  drive to cell A2 (= vec[1])
dut_a3  output  1  drive to cell A3 (= vec[2])
dut_a4  output  1  drive to cell A4 (= vec[3])
dut_b1  output  1  drive to cell B1 (= vec[4])
dut_x  input  1  cell output X
busy  output  1  high from the cycle after accepted start until the done cycle inclusive
done  output  1  one-cycle pulse at end of a full sweep
pass  output  1  result of last completed sweep (fail_count==0); valid while result_vld
result_vld  output  1  set with done, cleared on next accepted start
fail_count  output  6  number of mismatching vectors, 0..32, saturating at 32
first_fail_vec  output  5  index of the first mismatching vector; 0 when none
first_fail_vld  output  1  high once a mismatch is recorded in the current or last run

Behaviour:
- Reset values: all dut_* = 0, busy = 0, done = 0, pass = 0, result_vld = 0, fail_count = 0, first_fail_vec = 0, first_fail_vld = 0. The FSM goes to IDLE and the vector register vec = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE. Drive outputs are registered copies of vec.
- IDLE -> SETTLE on start & !abort. At that edge:
  - vec <= 0 and settle counter <= SETTLE_CYC-1.
  - fail_count, first_fail_*, result_vld and pass are cleared.
- SETTLE: the counter decrements each cycle. When it reaches 0, go to SAMPLE. Each vector is held for SETTLE_CYC cycles in SETTLE plus 1 cycle in SAMPLE.
- SAMPLE: expected = ~((vec[0]&vec[1])|(vec[2]&vec[3])|vec[4]).
  - If dut_x != expected: fail_count += 1 (saturating).
  - If dut_x != expected and first_fail_vld == 0: first_fail_vec <= vec and first_fail_vld <= 1.
  - If vec == 31: go to DONE.
  - Otherwise: vec <= vec+1, counter <= SETTLE_CYC-1, go to SETTLE.
- Vector order is ascending 0..31; no wrap-around within a run.
- DONE (one cycle): done = 1, result_vld <= 1, pass <= (fail_count == 0), busy still 1. Next state is IDLE. dut_* return to 0 on the IDLE entry edge.
- Latency: done is asserted exactly 32*(SETTLE_CYC+1)+1 cycles after the start cycle.
- abort in any non-IDLE state: next edge goes to IDLE, dut_* <= 0, busy <= 0, no done. Results stay as partial values and result_vld stays 0.
- start while busy is ignored. Simultaneous start & abort in IDLE: abort wins.
- Async reset mid-run: immediate return to reset values; no pulse glitches on done.
- The comparison uses dut_x as sampled at the clock edge. The settle requirement on the cell path is met by choosing SETTLE_CYC.

Optional Feature:
Macro `AOI_BIST_STOP_ON_FAIL_EN`.
- Defined: the first mismatch in SAMPLE goes directly to DONE. fail_count ends at 1, pass = 0 and the remaining vectors are skipped. done latency is (first_fail_vec+1)*(SETTLE_CYC+1)+1 cycles after start.
- Undefined: the full 32-vector sweep always runs, as above.

Test Plan:
1. Good cell model, SETTLE_CYC=2, pulse start -> busy for 97 cycles, done at cycle 97, pass=1, fail_count=0, first_fail_vld=0.
2. Cell with B1 stuck-at-0 -> vectors 16..31 with no AND term true mismatch (9 vectors: 16,17,18,20,21,22,24,25,26) -> fail_count=9, first_fail_vec=16, pass=0.
3. Cell with X inverted -> fail_count=32, first_fail_vec=0; with `AOI_BIST_STOP_ON_FAIL_EN`, done at cycle 4 after start, fail_count=1.
4. abort asserted 40 cycles into a run -> next cycle busy=0, dut_*=0, no done, result_vld=0; a following start gives a full clean run with pass=1.
5. start re-pulsed during a run and start+abort together in IDLE -> both ignored; the original done timing is unchanged and the FSM stays in IDLE respectively.
6. rst_n asserted mid-run at vector 10 -> all outputs read reset values immediately; after release, start runs the full sweep from vector 0.

Source files
------------

// File: rtl/aoi_cell_bist_ctrl.sv
// Self-test sequencer for the AOI cell X = ~((A1&A2)|(A3&A4)|B1): it sweeps all 32 input vectors
// and compares X with a golden model. Optional build macro: AOI_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module aoi_cell_bist_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a1,
  output logic       dut_a2,
  output logic       dut_a3,
  output logic       dut_a4,
  output logic       dut_b1,
  input  logic       dut_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       result_vld,
  output logic [5:0] fail_count,
  output logic [4:0] first_fail_vec,
  output logic       first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [5:0]       FAIL_MAX = 6'd32;

`ifdef AOI_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [4:0]       vec, vec_nxt;
  logic [4:0]       drv, drv_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       fail_cnt, fail_cnt_nxt;
  logic [4:0]       ff_vec, ff_vec_nxt;
  logic             ff_vld, ff_vld_nxt;
  logic             pass_r, pass_nxt;
  logic             rvld, rvld_nxt;
  logic             expected;
  logic             mismatch;

  assign expected = ~((vec[0] & vec[1]) | (vec[2] & vec[3]) | vec[4]);
  assign mismatch = (state == SAMPLE) && (dut_x != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      drv      <= '0;
      cnt      <= '0;
      fail_cnt <= '0;
      ff_vec   <= '0;
      ff_vld   <= 1'b0;
      pass_r   <= 1'b0;
      rvld     <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec      <= vec_nxt;
      drv      <= drv_nxt;
      cnt      <= cnt_nxt;
      fail_cnt <= fail_cnt_nxt;
      ff_vec   <= ff_vec_nxt;
      ff_vld   <= ff_vld_nxt;
      pass_r   <= pass_nxt;
      rvld     <= rvld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    cnt_nxt      = cnt;
    fail_cnt_nxt = fail_cnt;
    ff_vec_nxt   = ff_vec;
    ff_vld_nxt   = ff_vld;
    pass_nxt     = pass_r;
    rvld_nxt     = rvld;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt    = SETTLE;
          vec_nxt      = '0;
          cnt_nxt      = RELOAD;
          fail_cnt_nxt = '0;
          ff_vec_nxt   = '0;
          ff_vld_nxt   = 1'b0;
          pass_nxt     = 1'b0;
          rvld_nxt     = 1'b0;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          if (mismatch) begin
            if (fail_cnt != FAIL_MAX) fail_cnt_nxt = fail_cnt + 1'b1;
            if (!ff_vld) begin
              ff_vec_nxt = vec;
              ff_vld_nxt = 1'b1;
            end
          end
          if ((mismatch && STOP_ON_FAIL) || (vec == 5'd31)) begin
            state_nxt = DONE;
          end else begin
            vec_nxt   = vec + 5'd1;
            cnt_nxt   = RELOAD;
            state_nxt = SETTLE;
          end
        end
      end

      DONE: begin
        // done is already visible this cycle, so the sweep commits even if abort arrives now.
        state_nxt = IDLE;
        rvld_nxt  = 1'b1;
        pass_nxt  = (fail_cnt == '0);
      end

      default: state_nxt = IDLE;
    endcase
  end

  // The cell inputs follow vec while a run is active and park at zero in IDLE.
  always_comb begin
    drv_nxt = vec_nxt;
    if (state_nxt == IDLE) drv_nxt = '0;
  end

  assign dut_a1 = drv[0];
  assign dut_a2 = drv[1];
  assign dut_a3 = drv[2];
  assign dut_a4 = drv[3];
  assign dut_b1 = drv[4];

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign pass           = pass_r;
  assign result_vld     = rvld;
  assign fail_count     = fail_cnt;
  assign first_fail_vec = ff_vec;
  assign first_fail_vld = ff_vld;

endmodule

// File: tb/tb_aoi_cell_bist_ctrl.sv
// Directed bench for aoi_cell_bist_ctrl with a fault-injectable AOI cell model.
module tb_aoi_cell_bist_ctrl;
  localparam int SETTLE = 2;
  localparam int PER    = SETTLE + 1;
  localparam int FULL   = 32 * PER + 1;
  localparam int LIMIT  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_a1, dut_a2, dut_a3, dut_a4, dut_b1;
  logic       dut_x;
  logic       busy, done, pass, result_vld, first_fail_vld;
  logic [5:0] fail_count;
  logic [4:0] first_fail_vec;
  logic [4:0] drive;
  logic       good_x;
  int         fault = 0;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [4:0] exp_q[$];

  aoi_cell_bist_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_a1(dut_a1), .dut_a2(dut_a2), .dut_a3(dut_a3), .dut_a4(dut_a4), .dut_b1(dut_b1),
    .dut_x(dut_x), .busy(busy), .done(done), .pass(pass), .result_vld(result_vld),
    .fail_count(fail_count), .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld)
  );

  // clock / cell model
  always #5 clk = ~clk;

  assign drive  = {dut_b1, dut_a4, dut_a3, dut_a2, dut_a1};
  assign good_x = ~((dut_a1 & dut_a2) | (dut_a3 & dut_a4) | dut_b1);
  assign dut_x  = (fault == 2) ? ~good_x :
                  (fault == 1) ? ~((dut_a1 & dut_a2) | (dut_a3 & dut_a4)) : good_x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks; each returns on the negedge of the named cycle
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(output int lat);
    int c;
    pulse_start();
    c = 1;
    while (!done && c < LIMIT) begin
      @(negedge clk);
      c++;
    end
    lat = done ? c : -1;
    @(negedge clk);
  endtask

  task automatic run_monitored(input string tag);
    int c;
    int busy_cyc;
    exp_q.delete();
    for (int v = 0; v < 32; v++) exp_q.push_back(5'(v));
    pulse_start();
    c = 1;
    busy_cyc = 0;
    while (!done && c < LIMIT) begin
      if (((c - 1) % PER == 0) && exp_q.size() > 0) check({tag, "_vec"}, 32'(drive), 32'(exp_q.pop_front()));
      busy_cyc += int'(busy);
      @(negedge clk);
      c++;
    end
    busy_cyc += int'(busy);
    check({tag, "_done_at"}, 32'(done ? c : -1), 32'(FULL));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(FULL));
    check({tag, "_vec_left"}, 32'(exp_q.size()), 32'(0));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'(0));
    check({tag, "_drive_after"}, 32'(drive), 32'(0));
    check({tag, "_rvld"}, 32'(result_vld), 32'(1));
    check({tag, "_pass"}, 32'(pass), 32'(1));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(0));
    check({tag, "_ff_vld"}, 32'(first_fail_vld), 32'(0));
  endtask

  task automatic check_results(input string tag, input int lat, input int exp_lat,
                               input int exp_fails, input int exp_first);
    check({tag, "_done_at"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rvld"}, 32'(result_vld), 32'(1));
    check({tag, "_pass"}, 32'(pass), 32'(exp_fails == 0));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(exp_fails));
    check({tag, "_first_vec"}, 32'(first_fail_vec), 32'(exp_first));
    check({tag, "_first_vld"}, 32'(first_fail_vld), 32'(exp_fails != 0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_drive"}, 32'(drive), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(0));
    check({tag, "_rvld"}, 32'(result_vld), 32'(0));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(0));
    check({tag, "_first_vec"}, 32'(first_fail_vec), 32'(0));
    check({tag, "_first_vld"}, 32'(first_fail_vld), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c;
    logic saw_done;

    // reset
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle_busy", 32'(busy), 32'(0));

    // 1: good cell, full sweep with vector order and latency
    fault = 0;
    run_monitored("good");

    // 2: B1 stuck-at-0 mismatches on 16,17,18,20,21,22,24,25,26
    fault = 1;
    run_sweep(lat);
`ifdef AOI_BIST_STOP_ON_FAIL_EN
    check_results("b1_sa0", lat, 17 * PER + 1, 1, 16);
`else
    check_results("b1_sa0", lat, FULL, 9, 16);
`endif

    // 3: inverted output fails every vector
    fault = 2;
    run_sweep(lat);
`ifdef AOI_BIST_STOP_ON_FAIL_EN
    check_results("inv", lat, PER + 1, 1, 0);
`else
    check_results("inv", lat, FULL, 32, 0);
`endif

    // 4: abort 40 cycles into a run
    fault = 0;
    pulse_start();
    c = 1;
    saw_done = 1'b0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      saw_done |= done;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_drive", 32'(drive), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_rvld", 32'(result_vld), 32'(0));
    repeat (5) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", 32'(saw_done), 32'(0));
    check("abort_idle", 32'(busy), 32'(0));
    run_monitored("after_abort");

    // 5: start re-pulsed mid-run is ignored
    pulse_start();
    c = 1;
    while (!done && c < LIMIT) begin
      start = (c == 20 || c == 60);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("repulse_done_at", 32'(done ? c : -1), 32'(FULL));
    @(negedge clk);
    check("repulse_pass", 32'(pass), 32'(1));
    check("repulse_idle", 32'(busy), 32'(0));
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("start_abort_busy", 32'(busy), 32'(0));
    check("start_abort_drive", 32'(drive), 32'(0));
    check("start_abort_rvld", 32'(result_vld), 32'(1));
    @(negedge clk);
    check("start_abort_stay", 32'(busy), 32'(0));

    // 6: async reset while vector 10 is applied
    pulse_start();
    c = 1;
    while (c < 10 * PER + 2) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_vec", 32'(drive), 32'(10));
    check("rst_mid_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_busy", 32'(busy), 32'(0));
    run_monitored("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
